// File: rtl/mult_pkg.sv
// Shared types and constant helpers for the shift-add multiplier.
// Imported by the core and the rounding/saturation stage.
package mult_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin,
    StDone
  } state_e;

  // Width of an iteration counter that can hold the values 0..width.
  function automatic int unsigned cnt_width(int unsigned width);
    return $clog2(width + 1);
  endfunction

  // Half an LSB of the rescaled result, i.e. the round-half-up offset.
  function automatic int unsigned round_const(int unsigned frac_bits);
    return (frac_bits == 0) ? 32'd0 : (32'd1 << (frac_bits - 1));
  endfunction

endpackage

// File: rtl/mult_round_sat.sv
// Combinational Q-format rescale: round half up, shift by FRAC_BITS, then range
// check against WIDTH bits and clamp or wrap.
module mult_round_sat #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAC_BITS = 0,
  parameter int unsigned SATURATE  = 1
) (
  input  logic [2*WIDTH-1:0] product,
  input  logic               mode,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);
  import mult_pkg::*;

  localparam int unsigned PW = 2 * WIDTH;
  // Two guard bits: one for the rounding carry, one so unsigned stays positive.
  localparam int unsigned EW = PW + 2;
  localparam logic signed [EW-1:0] RndAdd = EW'(round_const(FRAC_BITS));

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] rounded;
  logic signed [EW-1:0] scaled;
  logic                 fits;
  logic [WIDTH-1:0]     sat_val;

  always_comb begin
    ext     = mode ? {{2{product[PW-1]}}, product} : {2'b00, product};
    rounded = ext + RndAdd;
    scaled  = rounded >>> FRAC_BITS;

    if (mode) begin
      fits    = (&scaled[EW-1:WIDTH-1]) | ~(|scaled[EW-1:WIDTH-1]);
      sat_val = scaled[EW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      fits    = ~(|scaled[EW-1:WIDTH]);
      sat_val = {WIDTH{1'b1}};
    end

    overflow = ~fits;
    result   = (!fits && (SATURATE != 0)) ? sat_val : scaled[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_shiftadd_core.sv
// Sequential shift-add multiplier, one multiplier bit per clock, with signed mode,
// fixed-point rescaling and valid/ready handshakes on both sides.
module mult_shiftadd_core #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAC_BITS = 0,
  parameter int unsigned SATURATE  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   result,
  output logic               overflow,
  output logic               busy
);
  import mult_pkg::*;

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [PW-1:0]    mplier_q;
  logic [PW-1:0]    acc_q;
  logic             sign_a_q, sign_b_q, mode_q;

  logic [PW-1:0]    product_q;
  logic [WIDTH-1:0] result_q;
  logic             overflow_q;

  logic             accept;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [PW-1:0]    signed_prod;
  logic [WIDTH-1:0] rs_result;
  logic             rs_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (cnt_q == LastCnt) state_d = StFin;
      StFin:   state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle:  in_ready  = 1'b1;
      StRun:   busy      = 1'b1;
      StFin:   busy      = 1'b1;
      StDone:  out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  assign accept = (state_q == StIdle) && in_valid;

  // Magnitudes in WIDTH-bit unsigned: the most negative value maps to 2^(WIDTH-1).
  assign abs_a = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign abs_b = (signed_mode && b[WIDTH-1]) ? -b : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mode_q   <= 1'b0;
    end else if (accept) begin
      cnt_q    <= '0;
      mcand_q  <= abs_a;
      mplier_q <= {{WIDTH{1'b0}}, abs_b};
      acc_q    <= '0;
      sign_a_q <= signed_mode & a[WIDTH-1];
      sign_b_q <= signed_mode & b[WIDTH-1];
      mode_q   <= signed_mode;
    end else if (state_q == StRun) begin
      if (mcand_q[0]) acc_q <= acc_q + mplier_q;
      mplier_q <= mplier_q << 1;
      mcand_q  <= mcand_q >> 1;
      cnt_q    <= cnt_q + CntW'(1);
    end
  end

  assign signed_prod = (mode_q && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;

  mult_round_sat #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .SATURATE  (SATURATE)
  ) u_round_sat (
    .product  (signed_prod),
    .mode     (mode_q),
    .result   (rs_result),
    .overflow (rs_overflow)
  );

  // Results persist past DONE until the next FIN overwrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q  <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else if (state_q == StFin) begin
      product_q  <= signed_prod;
      result_q   <= rs_result;
      overflow_q <= rs_overflow;
    end
  end

  assign product  = product_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mult_shiftadd_core.sv
// Scoreboard bench: three cores (F=0 sat, F=0 wrap, F=4 sat) share one stimulus
// stream; an arithmetic reference model predicts every result.
module tb_mult_shiftadd_core;

  localparam int W  = 8;
  localparam int ND = 3;

  typedef struct packed {
    logic [2*W-1:0]       p;
    logic [ND-1:0][W-1:0] r;
    logic [ND-1:0]        ov;
    logic [31:0]          acc;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           signed_mode;
  logic           out_ready;

  logic           in_ready_w  [ND];
  logic           out_valid_w [ND];
  logic [2*W-1:0] product_w   [ND];
  logic [W-1:0]   result_w    [ND];
  logic           overflow_w  [ND];
  logic           busy_w      [ND];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   rdy_mode = 0;
  bit   lat_done = 0;
  exp_t sbq[$];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    mult_shiftadd_core #(
      .WIDTH     (W),
      .FRAC_BITS ((g == 2) ? 4 : 0),
      .SATURATE  ((g == 1) ? 0 : 1)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready_w[g]),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .out_valid   (out_valid_w[g]),
      .out_ready   (out_ready),
      .product     (product_w[g]),
      .result      (result_w[g]),
      .overflow    (overflow_w[g]),
      .busy        (busy_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer product, round half up, floor-shift, then range rules.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic m, input int acc);
    exp_t        e;
    longint      sa, sb, p, s, lo, hi;
    logic [63:0] pv, sv;
    int          f;
    bit          sat;
    sa = m ? longint'($signed(ma)) : longint'(ma);
    sb = m ? longint'($signed(mb)) : longint'(mb);
    p  = sa * sb;
    pv = p;
    e.p   = pv[2*W-1:0];
    e.acc = acc;
    lo = m ? -(longint'(1) << (W - 1)) : 0;
    hi = m ? (longint'(1) << (W - 1)) - 1 : (longint'(1) << W) - 1;
    for (int g = 0; g < ND; g++) begin
      f   = (g == 2) ? 4 : 0;
      sat = (g != 1);
      s   = p;
      if (f > 0) s = s + (longint'(1) << (f - 1));
      s = s >>> f;
      e.ov[g] = (s < lo) || (s > hi);
      if (sat && s < lo) s = lo;
      else if (sat && s > hi) s = hi;
      sv = s;
      e.r[g] = sv[W-1:0];
    end
    return e;
  endfunction

  // Monitor: compares every cycle out_valid is high (so stalls are checked for
  // stability) and pops on the handshake.
  always @(negedge clk) begin
    if (rst_n && (out_valid_w[0] || out_valid_w[1] || out_valid_w[2])) begin
      if (sbq.size() == 0) begin
        check("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        if (!lat_done) begin
          check("latency", cyc - sbq[0].acc, W + 1);
          lat_done = 1;
        end
        for (int g = 0; g < ND; g++) begin
          check($sformatf("out_valid[%0d]", g), out_valid_w[g], 1);
          check($sformatf("product[%0d]", g), product_w[g], sbq[0].p);
          check($sformatf("result[%0d]", g), result_w[g], sbq[0].r[g]);
          check($sformatf("overflow[%0d]", g), overflow_w[g], sbq[0].ov[g]);
          check($sformatf("in_ready_done[%0d]", g), in_ready_w[g], 0);
          check($sformatf("busy_done[%0d]", g), busy_w[g], 0);
        end
        if (out_ready) begin
          void'(sbq.pop_front());
          lat_done = 0;
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    for (int g = 0; g < ND; g++) begin
      check($sformatf("%s_in_ready[%0d]", tag, g), in_ready_w[g], 1);
      check($sformatf("%s_out_valid[%0d]", tag, g), out_valid_w[g], 0);
      check($sformatf("%s_busy[%0d]", tag, g), busy_w[g], 0);
      check($sformatf("%s_product[%0d]", tag, g), product_w[g], 0);
      check($sformatf("%s_result[%0d]", tag, g), result_w[g], 0);
      check($sformatf("%s_overflow[%0d]", tag, g), overflow_w[g], 0);
    end
  endtask

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tm, input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready_w[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", in_ready_w[0], 1);
    a           = ta;
    b           = tb;
    signed_mode = tm;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    if (push) sbq.push_back(model(ta, tb, tm, cyc));
    in_valid    = 1'b0;
    a           = W'($urandom);
    b           = W'($urandom);
    signed_mode = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", sbq.size(), 0);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 8'h80;
      2:       return 8'hFF;
      3:       return 8'h7F;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    signed_mode = 1'b0;
    out_ready   = 1'b1;
    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: plain, overflow, signed, most-negative, Q4 and rounding.
    issue(8'd13, 8'd11, 1'b0, 1);
    issue(8'd200, 8'd200, 1'b0, 1);
    issue(8'hF9, 8'h06, 1'b1, 1);
    issue(8'h80, 8'h80, 1'b1, 1);
    issue(8'h18, 8'h28, 1'b1, 1);
    issue(8'h01, 8'h08, 1'b1, 1);
    issue(8'h00, 8'hFF, 1'b0, 1);
    drain();

    // Backpressure: stall in DONE with in_valid pulses that must be ignored.
    rdy_mode = 2;
    @(posedge clk);
    #1;
    issue(8'h37, 8'h5A, 1'b0, 1);
    n = 0;
    while (!out_valid_w[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall_out_valid_seen", out_valid_w[0], 1);
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = W'($urandom);
      b        = W'($urandom);
    end
    rdy_mode = 0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_done_in_ready", in_ready_w[0], 1);
    check("post_done_out_valid", out_valid_w[0], 0);
    check("post_done_product_held", product_w[0], 16'h37 * 16'h5A);
    issue(8'hF0, 8'h03, 1'b1, 1);
    drain();

    // Asynchronous reset after three iterations of an operation.
    issue(8'hAB, 8'hCD, 1'b0, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrun_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(8'd5, 8'd5, 1'b0, 1);
    drain();

    // Randomised operands, modes and consumer backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      issue(pick_operand(), pick_operand(), 1'($urandom), 1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
